// File: rtl/dot_product_ctrl_pkg.sv
// Shared widths, state encoding and timing constants for the dot-product sequencer.
package dot_product_ctrl_pkg;

  localparam int unsigned DP_ADDR_W    = 8;
  localparam int unsigned DP_LEN_W     = 9;
  localparam int unsigned DP_ACC_W     = 16;
  localparam int unsigned DP_RD_LAT    = 1;
  localparam int unsigned DRAIN_CYCLES = 2;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_CLEAR  = 3'd1;
  localparam logic [STATE_W-1:0] S_ISSUE  = 3'd2;
  localparam logic [STATE_W-1:0] S_DRAIN  = 3'd3;
  localparam logic [STATE_W-1:0] S_RESULT = 3'd4;

endpackage

// File: rtl/dot_product_ctrl_addr_gen.sv
// Element index counter and the two base+index address adders for the operand memories.
module dp_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_x,
  input  logic [ADDR_W-1:0] base_w,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              last_c
);

  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  // Addresses track the index of the coming cycle so they appear registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      x_addr <= '0;
      w_addr <= '0;
    end else if (load || advance) begin
      idx_q  <= idx_d;
      x_addr <= base_x + ADDR_W'(idx_d);
      w_addr <= base_w + ADDR_W'(idx_d);
    end
  end

  assign last_c = (idx_q == (len - LEN_W'(1)));

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: clears the MAC, streams operand reads, captures the accumulated result.
module dot_product_ctrl
  import dot_product_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DP_ADDR_W,
  parameter int unsigned LEN_W  = DP_LEN_W,
  parameter int unsigned ACC_W  = DP_ACC_W,
  parameter int unsigned RD_LAT = DP_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_x,
  input  logic [ADDR_W-1:0] base_w,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_clear,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  result_data,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t              state_q;
  state_t              state_d;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   base_x_q;
  logic [ADDR_W-1:0]   base_w_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic [RD_LAT-1:0]   rd_pipe_q;
  logic                last_c;
  logic                load_c;
  logic                advance_c;
  logic                drain_done_c;

  assign load_c       = (state_q == S_CLEAR);
  assign advance_c    = (state_q == S_ISSUE);
  assign drain_done_c = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));
  assign busy         = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = (len_q != '0) ? S_ISSUE : S_DRAIN;
      S_ISSUE:  if (last_c) state_d = S_DRAIN;
      S_DRAIN:  if (drain_done_c) state_d = S_RESULT;
      S_RESULT: if (result_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      base_x_q <= '0;
      base_w_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      len_q    <= len;
      base_x_q <= base_x;
      base_w_q <= base_w;
    end
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_clear   <= 1'b0;
      mem_rd_en   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      mac_clear   <= (state_d == S_CLEAR);
      mem_rd_en   <= (state_d == S_ISSUE);
      drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_pipe_q <= '0;
      end else begin
        rd_pipe_q[0] <= mem_rd_en;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_pipe_q <= '0;
      end else begin
        rd_pipe_q <= {rd_pipe_q[RD_LAT-2:0], mem_rd_en};
      end
    end
  end

  assign mac_en = rd_pipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      result_data  <= '0;
      result_valid <= 1'b0;
    end else if (state_q == S_DRAIN && drain_done_c) begin
      result_data  <= mac_acc;
      result_valid <= 1'b1;
    end else if (state_q == S_RESULT && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  dp_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .advance (advance_c),
    .len     (len_q),
    .base_x  (base_x_q),
    .base_w  (base_w_q),
    .x_addr  (x_addr),
    .w_addr  (w_addr),
    .last_c  (last_c)
  );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl with behavioural operand memories, MAC and dot-product model.
module tb_dot_product_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  base_x;
  logic [7:0]  base_w;
  logic        busy;
  logic        mem_rd_en;
  logic [7:0]  x_addr;
  logic [7:0]  w_addr;
  logic        mac_clear;
  logic        mac_en;
  logic [15:0] mac_acc;
  logic [15:0] result_data;
  logic        result_valid;
  logic        result_ready;

  logic [7:0]  x_mem [256];
  logic [7:0]  w_mem [256];
  logic [7:0]  x_data;
  logic [7:0]  w_data;

  int errors = 0;
  int checks = 0;
  int clr_q[$];
  int en_q[$];
  int xa_q[$];
  int wa_q[$];
  int valid_cyc;
  logic [15:0] got_res;

  always #5 clk = ~clk;

  dot_product_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .base_x       (base_x),
    .base_w       (base_w),
    .busy         (busy),
    .mem_rd_en    (mem_rd_en),
    .x_addr       (x_addr),
    .w_addr       (w_addr),
    .mac_clear    (mac_clear),
    .mac_en       (mac_en),
    .mac_acc      (mac_acc),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // Operand SRAMs with one-cycle read latency and a wrapping 8x8->16 MAC.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      x_data <= x_mem[x_addr];
      w_data <= w_mem[w_addr];
    end
    if (reset || mac_clear) mac_acc <= 16'd0;
    else if (mac_en) mac_acc <= mac_acc + 16'(16'(x_data) * 16'(w_data));
  end

  function automatic logic [15:0] ref_dot(input int l, input int bx, input int bw);
    int unsigned s = 0;
    for (int i = 0; i < l; i++)
      s += int'(x_mem[(bx + i) % 256]) * int'(w_mem[(bw + i) % 256]);
    return 16'(s);
  endfunction

  task automatic issue_cmd(input int l, input int bx, input int bw, input logic rdy);
    clr_q.delete(); en_q.delete(); xa_q.delete(); wa_q.delete();
    valid_cyc = -1;
    @(negedge clk);
    start = 1'b1; len = 9'(l); base_x = 8'(bx); base_w = 8'(bw); result_ready = rdy;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (mac_clear) clr_q.push_back(c);
      if (mac_en) en_q.push_back(c);
      if (mem_rd_en) begin
        xa_q.push_back(int'(x_addr));
        wa_q.push_back(int'(w_addr));
      end
      if (result_valid) begin
        valid_cyc = c;
        got_res = result_data;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (valid_cyc < 0) begin
      errors++;
      $display("FAIL cmd_timeout: result_valid never rose for len=%0d", l);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; result_ready = 1'b0;
    len = '0; base_x = '0; base_w = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    checks++; if (x_addr !== 8'd0) begin errors++; $display("FAIL rst_x_addr: got %0d want 0", x_addr); end
    checks++; if (w_addr !== 8'd0) begin errors++; $display("FAIL rst_w_addr: got %0d want 0", w_addr); end
    checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL rst_mac_clear: got %b want 0", mac_clear); end
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL rst_mac_en: got %b want 0", mac_en); end
    checks++; if (result_data !== 16'd0) begin errors++; $display("FAIL rst_result_data: got %0d want 0", result_data); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit bad;
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = 8'(i + 1);
      w_mem[16 + i] = 8'(i + 5);
    end
    issue_cmd(4, 0, 16, 1'b1);
    checks++; if (got_res !== 16'd70) begin errors++; $display("FAIL basic_result: got %0d want 70", got_res); end
    checks++; if (valid_cyc != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", valid_cyc); end
    bad = (en_q.size() != 4);
    for (int i = 0; i < en_q.size() && i < 4; i++) if (en_q[i] != 3 + i) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL basic_mac_en: got %0d pulses starting %0d want 4 at cycles 3..6", en_q.size(), (en_q.size() > 0) ? en_q[0] : -1); end
    checks++; if (clr_q.size() != 1 || clr_q[0] != 1) begin errors++; $display("FAIL basic_mac_clear: got %0d pulses want 1 at cycle 1", clr_q.size()); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_handshake: valid=%b busy=%b want 0 0", result_valid, busy); end
  endtask

  task automatic test_zero_len();
    issue_cmd(0, 3, 7, 1'b1);
    checks++; if (got_res !== 16'd0) begin errors++; $display("FAIL zero_result: got %0d want 0", got_res); end
    checks++; if (valid_cyc != 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", valid_cyc); end
    checks++; if (en_q.size() != 0 || xa_q.size() != 0) begin errors++; $display("FAIL zero_pulses: mac_en=%0d rd=%0d want 0 0", en_q.size(), xa_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    x_mem[40] = 8'd255; x_mem[41] = 8'd255;
    w_mem[80] = 8'd255; w_mem[81] = 8'd255;
    issue_cmd(2, 40, 80, 1'b1);
    checks++; if (got_res !== 16'd64514) begin errors++; $display("FAIL overflow_result: got %0d want 64514", got_res); end
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    bit bad;
    issue_cmd(4, 254, 0, 1'b1);
    bad = (xa_q.size() != 4) || (wa_q.size() != 4);
    for (int i = 0; i < xa_q.size() && i < 4; i++)
      if (xa_q[i] != (254 + i) % 256 || wa_q[i] != i) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL wrap_addr: got %0d reads first x=%0d want x 254,255,0,1 w 0..3", xa_q.size(), (xa_q.size() > 0) ? xa_q[0] : -1); end
    checks++; if (got_res !== ref_dot(4, 254, 0)) begin errors++; $display("FAIL wrap_result: got %0d want %0d", got_res, ref_dot(4, 254, 0)); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    exp = ref_dot(6, 10, 100);
    issue_cmd(6, 10, 100, 1'b0);
    checks++; if (got_res !== exp) begin errors++; $display("FAIL bp_result: got %0d want %0d", got_res, exp); end
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      len = 9'($urandom_range(0, 20));
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || result_data !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b data=%0d busy=%b want 1 %0d 1", k, result_valid, result_data, busy, exp);
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b busy=%b want 0 0", result_valid, busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || mac_clear !== 1'b0) begin errors++; $display("FAIL bp_no_queue: busy=%b clear=%b want 0 0", busy, mac_clear); end
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    start = 1'b1; len = 9'd8; base_x = 8'd0; base_w = 8'd16; result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || mac_en !== 1'b0 || mac_clear !== 1'b0 ||
        x_addr !== 8'd0 || w_addr !== 8'd0 || result_valid !== 1'b0 || result_data !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rd=%b en=%b clr=%b xa=%0d wa=%0d v=%b d=%0d want all 0",
               busy, mem_rd_en, mac_en, mac_clear, x_addr, w_addr, result_valid, result_data);
    end
    reset = 1'b0;
    issue_cmd(4, 0, 16, 1'b1);
    checks++; if (got_res !== 16'd70) begin errors++; $display("FAIL mid_reset_rerun: got %0d want 70", got_res); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int clr_cyc[$];
    @(negedge clk);
    start = 1'b1; len = 9'd3; base_x = 8'd5; base_w = 8'd9; result_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mac_clear) clr_cyc.push_back(c);
      if (clr_cyc.size() >= 2) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (clr_cyc.size() != 2 || clr_cyc[1] - clr_cyc[0] != 8) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d clears spacing %0d want 2 spacing 8", clr_cyc.size(),
               (clr_cyc.size() >= 2) ? clr_cyc[1] - clr_cyc[0] : -1);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    int l, bx, bw, hold;
    logic [15:0] exp;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 256; i++) begin
        x_mem[i] = 8'($urandom);
        w_mem[i] = 8'($urandom);
      end
      l = (n == 7) ? 256 : $urandom_range(0, 24);
      bx = $urandom_range(0, 255);
      bw = $urandom_range(0, 255);
      hold = $urandom_range(0, 3);
      exp = ref_dot(l, bx, bw);
      issue_cmd(l, bx, bw, 1'b0);
      checks++; if (got_res !== exp) begin errors++; $display("FAIL rand_result[%0d]: got %0d want %0d", n, got_res, exp); end
      checks++; if (valid_cyc != l + 4 || en_q.size() != l) begin errors++; $display("FAIL rand_timing[%0d]: valid at %0d en=%0d want %0d %0d", n, valid_cyc, en_q.size(), l + 4, l); end
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result_data !== exp) begin errors++; $display("FAIL rand_hold[%0d]: valid=%b data=%0d want 1 %0d", n, result_valid, result_data, exp); end
      end
      result_ready = 1'b1;
      @(negedge clk);
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_release[%0d]: valid=%b busy=%b want 0 0", n, result_valid, busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = 8'd0;
      w_mem[i] = 8'd0;
    end
    reset = 1'b1; start = 1'b0; result_ready = 1'b0;
    len = '0; base_x = '0; base_w = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_addr_wrap();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
Sequencer that computes one dot product of two 8-bit vectors on the shared 8x8->16 MAC datapath. On a start command it clears the MAC accumulator, then walks two operand memories (x and w) from programmable base addresses. It enables the MAC once per element, aligned to the memory read latency. It returns the final accumulator value over a valid/ready result interface and sits between the layer-level scheduler and the MAC plus its operand SRAMs.

Parameters:
ADDR_W, 8, operand memory address width; addresses wrap modulo 2^ADDR_W
LEN_W, 9, vector length field width; legal length 0..2^ADDR_W
ACC_W, 16, MAC accumulator / result width
RD_LAT, 1, operand memory read latency in cycles; fixed at 1 for this revision

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high; all state and outputs return to reset values
start  in  1  command strobe; sampled only in IDLE
len  in  LEN_W  element count, latched on accepted start
base_x  in  ADDR_W  x vector base address, latched on accepted start
base_w  in  ADDR_W  w vector base address, latched on accepted start
busy  out  1  high in every state except IDLE
mem_rd_en  out  1  read strobe to both operand memories
x_addr  out  ADDR_W  x memory address
w_addr  out  ADDR_W  w memory address
mac_clear  out  1  one-cycle accumulator clear; ORed with reset at the MAC
mac_en  out  1  MAC accumulate enable
mac_acc  in  ACC_W  MAC accumulator value
result_data  out  ACC_W  dot-product result, stable while result_valid
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset values: busy=0, mem_rd_en=0, x_addr=0, w_addr=0, mac_clear=0, mac_en=0, result_data=0, result_valid=0; FSM=IDLE; index counter=0.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, RESULT.
- IDLE: if start=1, latch len/base_x/base_w and go to CLEAR. Otherwise stay.
- CLEAR: exactly 1 cycle with mac_clear=1. Next state is ISSUE if len_q!=0, else DRAIN.
- ISSUE: mem_rd_en=1, x_addr=base_x+idx, w_addr=base_w+idx (mod 2^ADDR_W); idx runs 0..len_q-1, one element per cycle. Leave for DRAIN after idx=len_q-1.
- mac_en is mem_rd_en delayed by one register (RD_LAT=1), so data arriving at the MAC and its enable coincide. mac_en=0 at all other times.
- DRAIN: exactly 2 cycles, letting the last accumulate land. On the edge ending the second DRAIN cycle, result_data<=mac_acc, result_valid<=1, go to RESULT.
- RESULT: hold result_data and result_valid until result_ready=1. The handshake cycle returns to IDLE and result_valid drops the next cycle.
- Latency: start accepted at cycle 0 -> result_valid first high at cycle len+4. For len=0 this is cycle 4 with result 0.
- Throughput: a new start is accepted only in IDLE. Minimum command-to-command spacing is len+5 cycles with result_ready tied high.
- start while busy=1: ignored, no queuing.
- Arithmetic: no saturation. result = sum(x[i]*w[i]) mod 2^ACC_W, inherited from the MAC's wrapping accumulator.
- Address wrap: base+idx overflow wraps silently. len > 2^ADDR_W is illegal and its behaviour is undefined.
- Reset mid-operation, any state: next cycle all outputs hold reset values and the FSM is in IDLE. The partial accumulation is discarded, and the next command's CLEAR guarantees a fresh sum.
- All outputs are registered, except busy, which may decode from state.

Decomposition:
- Package dot_product_ctrl_pkg: state enum (IDLE, CLEAR, ISSUE, DRAIN, RESULT), DRAIN_CYCLES=2 constant, default width localparams.
- One sub-module, dp_addr_gen: index counter with load/advance/last flag plus the two base+index adders.
- FSM, mac_en delay register and result register stay in dot_product_ctrl.

Test Plan:
- Basic: len=4, base_x=0, base_w=16, x={1,2,3,4}, w={5,6,7,8}, ready=1 -> result_data=70, valid at cycle 8. mac_en high cycles 3..6, mac_clear high cycle 1.
- Zero length: len=0 -> no mem_rd_en or mac_en pulses, result_data=0, valid at cycle 4.
- Overflow and wrap: len=2, x={255,255}, w={255,255} -> result_data=64514 (130050 mod 65536).
- Address wrap: base_x=254, base_w=0, len=4 -> x_addr sequence 254,255,0,1 and w_addr sequence 0,1,2,3 on consecutive ISSUE cycles.
- Backpressure: result_ready low 10 cycles after valid -> result_data and valid stable throughout. Starts pulsed during this window are ignored. Raising ready returns to IDLE and busy=0 the next cycle.
- Reset mid-ISSUE: len=8, reset at cycle 4 -> all outputs 0 the next cycle. A new start with len=4 and the basic vectors yields 70, not a contaminated sum.
